// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding, NOP encoding,
// IF/ID payload and RV32 field bit positions.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

    localparam int unsigned OPCODE_LSB = 2;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode is stalled.
module fetch_skid_buf
    import instr_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drop,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic [XLEN-1:0] buf_pc,
    output logic [XLEN-1:0] buf_instr,
    output logic            buf_valid
);

    fetch_entry_t entry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q   <= '0;
            buf_valid <= 1'b0;
        end else if (drop) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            entry_q   <= '{pc: load_pc, instr: load_instr};
            buf_valid <= 1'b1;
        end
    end

    assign buf_pc    = entry_q.pc;
    assign buf_instr = entry_q.instr;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding-request fetch FSM feeding the
// IF/ID register, with a one-entry skid buffer for decode stalls.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPC,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemValid,
    input  logic [31:0] i_imemData,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            ifid_load, ifid_from_buf;
    logic            skid_load, skid_drop;
    logic [XLEN-1:0] buf_pc, buf_instr;
    logic            buf_valid;

    fetch_skid_buf u_skid (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (skid_load),
        .drop       (skid_drop),
        .load_pc    (fetch_pc_q),
        .load_instr (i_imemData),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr),
        .buf_valid  (buf_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next state and fetch-side controls; a redirect overrides every fetch event.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        ifid_load     = 1'b0;
        ifid_from_buf = 1'b0;
        skid_load     = 1'b0;
        skid_drop     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (i_redirect) begin
                    fetch_pc_d = word_align(i_redirectPC);
                    if (!i_imemValid) state_d = ST_DISCARD;
                end else if (i_imemValid) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (i_stall) begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (i_redirect) begin
                    fetch_pc_d = word_align(i_redirectPC);
                    skid_drop  = 1'b1;
                    state_d    = ST_FETCH;
                end else if (!i_stall) begin
                    ifid_load     = 1'b1;
                    ifid_from_buf = 1'b1;
                    skid_drop     = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (i_redirect) fetch_pc_d = word_align(i_redirectPC);
                if (i_imemValid) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // IF/ID register; with decode free and nothing to load, a bubble is inserted
    // so the previous instruction is not presented twice.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
            o_pc    <= PC_RESET;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
        end else if (!i_stall) begin
            if (ifid_load) begin
                o_valid <= ifid_from_buf ? buf_valid : 1'b1;
                o_pc    <= ifid_from_buf ? buf_pc    : fetch_pc_q;
                o_instr <= ifid_from_buf ? buf_instr : i_imemData;
            end else begin
                o_valid <= 1'b0;
                o_instr <= NOP_INSTR;
            end
        end
    end

    assign o_imemReq  = (state_q == ST_FETCH) && !i_rst;
    assign o_imemAddr = fetch_pc_q;

    assign o_opcode = o_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_rd     = o_instr[RD_MSB:RD_LSB];
    assign o_funct3 = o_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign o_rs1    = o_instr[RS1_MSB:RS1_LSB];
    assign o_rs2    = o_instr[RS2_MSB:RS2_LSB];
    assign o_funct7 = o_instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: nominal streaming, memory latency, stall/skid,
// redirect/discard, flush, reset and PC wraparound.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, redirect, imem_valid;
    logic [31:0] redirect_pc, imem_data;

    logic        a_req, a_valid;
    logic [31:0] a_addr, a_pc, a_instr;
    logic [4:0]  a_opcode, a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3;
    logic [6:0]  a_funct7;

    logic        b_req, b_valid;
    logic [31:0] b_addr, b_pc, b_instr;
    logic [4:0]  b_opcode, b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic [6:0]  b_funct7;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.PC_RESET(32'h0000_0100)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
        .i_redirect(redirect), .i_redirectPC(redirect_pc),
        .o_imemReq(a_req), .o_imemAddr(a_addr),
        .i_imemValid(imem_valid), .i_imemData(imem_data),
        .o_valid(a_valid), .o_pc(a_pc), .o_instr(a_instr),
        .o_opcode(a_opcode), .o_funct3(a_funct3), .o_funct7(a_funct7),
        .o_rd(a_rd), .o_rs1(a_rs1), .o_rs2(a_rs2)
    );

    instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_stall(1'b0), .i_flush(1'b0),
        .i_redirect(1'b0), .i_redirectPC(32'h0),
        .o_imemReq(b_req), .o_imemAddr(b_addr),
        .i_imemValid(1'b1), .i_imemData(32'h0000_0033),
        .o_valid(b_valid), .o_pc(b_pc), .o_instr(b_instr),
        .o_opcode(b_opcode), .o_funct3(b_funct3), .o_funct7(b_funct7),
        .o_rd(b_rd), .o_rs1(b_rs1), .o_rs2(b_rs2)
    );

    function automatic logic [31:0] mk(input logic [31:0] addr);
        return {addr[15:0], 16'hA0B3};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s,
                         input logic f, input logic r, input logic [31:0] rpc);
        imem_valid  = v;
        imem_data   = d;
        stall       = s;
        flush       = f;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check_eq("rst_req",   32'(a_req),   32'd0);
        check_eq("rst_valid", 32'(a_valid), 32'd0);
        check_eq("rst_instr", a_instr,      32'h0000_0013);
        check_eq("rst_pc",    a_pc,         32'h0000_0100);

        // Zero-latency streaming from 0x100
        rst = 1'b0;
        drive(1'b1, mk(32'h100), 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("c0_req",   32'(a_req), 32'd1);
        check_eq("c0_addr",  a_addr,     32'h0000_0100);
        check_eq("c0_valid", 32'(a_valid), 32'd0);
        check_eq("wrap_addr0", b_addr,   32'hFFFF_FFFC);
        tick();
        check_eq("c1_addr",  a_addr,     32'h0000_0104);
        check_eq("c1_valid", 32'(a_valid), 32'd1);
        check_eq("c1_pc",    a_pc,       32'h0000_0100);
        check_eq("c1_instr", a_instr,    mk(32'h100));
        w = mk(32'h100);
        check_eq("c1_opcode", 32'(a_opcode), 32'(w[6:2]));
        check_eq("c1_rd",     32'(a_rd),     32'(w[11:7]));
        check_eq("c1_funct3", 32'(a_funct3), 32'(w[14:12]));
        check_eq("c1_rs1",    32'(a_rs1),    32'(w[19:15]));
        check_eq("c1_rs2",    32'(a_rs2),    32'(w[24:20]));
        check_eq("c1_funct7", 32'(a_funct7), 32'(w[31:25]));
        check_eq("wrap_addr1", b_addr,       32'h0000_0000);
        check_eq("wrap_pc",    b_pc,         32'hFFFF_FFFC);
        drive(1'b1, mk(32'h104), 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("c2_addr", a_addr, 32'h0000_0108);
        check_eq("c2_pc",   a_pc,   32'h0000_0104);

        // Three-cycle memory latency on 0x108
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("lat_addr1",  a_addr,      32'h0000_0108);
        check_eq("lat_req1",   32'(a_req),  32'd1);
        check_eq("lat_bubble", 32'(a_valid), 32'd0);
        tick();
        check_eq("lat_addr2",  a_addr,      32'h0000_0108);
        drive(1'b1, mk(32'h108), 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("lat_pc",    a_pc,         32'h0000_0108);
        check_eq("lat_instr", a_instr,      mk(32'h108));
        check_eq("lat_valid", 32'(a_valid), 32'd1);
        check_eq("lat_next",  a_addr,       32'h0000_010C);

        // Stall on 0x10C response, held two cycles: skid then release
        drive(1'b1, mk(32'h10C), 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("hold_req1", 32'(a_req), 32'd0);
        check_eq("hold_addr", a_addr,     32'h0000_0110);
        check_eq("hold_pc1",  a_pc,       32'h0000_0108);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("hold_pc2",    a_pc,         32'h0000_0108);
        check_eq("hold_valid2", 32'(a_valid), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("skid_pc",    a_pc,       32'h0000_010C);
        check_eq("skid_instr", a_instr,    mk(32'h10C));
        check_eq("skid_req",   32'(a_req), 32'd1);
        check_eq("skid_addr",  a_addr,     32'h0000_0110);
        drive(1'b1, mk(32'h110), 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("post_skid_pc", a_pc,   32'h0000_0110);
        check_eq("post_skid_addr", a_addr, 32'h0000_0114);

        // Redirect to 0x202 (aligned to 0x200) with 0x114 outstanding
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0202);
        tick();
        check_eq("disc_req",   32'(a_req),   32'd0);
        check_eq("disc_addr",  a_addr,       32'h0000_0200);
        check_eq("disc_valid", 32'(a_valid), 32'd0);
        check_eq("disc_instr", a_instr,      32'h0000_0013);
        check_eq("disc_pc",    a_pc,         32'h0000_0110);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("disc_req2", 32'(a_req), 32'd0);
        drive(1'b1, mk(32'h114), 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("disc_drop_valid", 32'(a_valid), 32'd0);
        check_eq("disc_drop_pc",    a_pc,         32'h0000_0110);
        check_eq("refetch_req",     32'(a_req),   32'd1);
        check_eq("refetch_addr",    a_addr,       32'h0000_0200);
        drive(1'b1, mk(32'h200), 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("tgt_pc",    a_pc,    32'h0000_0200);
        check_eq("tgt_instr", a_instr, mk(32'h200));

        // Flush together with stall
        drive(1'b1, mk(32'h204), 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check_eq("fs_valid", 32'(a_valid), 32'd0);
        check_eq("fs_instr", a_instr,      32'h0000_0013);
        check_eq("fs_pc",    a_pc,         32'h0000_0200);
        check_eq("fs_req",   32'(a_req),   32'd0);

        // Redirect in HOLD drops the buffered 0x204
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
        tick();
        check_eq("hr_req",   32'(a_req),   32'd1);
        check_eq("hr_addr",  a_addr,       32'h0000_0300);
        check_eq("hr_valid", 32'(a_valid), 32'd0);
        check_eq("hr_pc",    a_pc,         32'h0000_0200);

        // Redirect coincident with a response drops that response
        drive(1'b1, mk(32'h300), 1'b0, 1'b0, 1'b1, 32'h0000_0400);
        tick();
        check_eq("fr_addr",  a_addr,       32'h0000_0400);
        check_eq("fr_req",   32'(a_req),   32'd1);
        check_eq("fr_valid", 32'(a_valid), 32'd0);

        // Reset mid-request, late response accepted as PC_RESET data
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_eq("rr_req",   32'(a_req),   32'd0);
        check_eq("rr_pc",    a_pc,         32'h0000_0100);
        check_eq("rr_valid", 32'(a_valid), 32'd0);
        rst = 1'b0;
        drive(1'b1, mk(32'h100), 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("rr_addr", a_addr, 32'h0000_0100);
        tick();
        check_eq("rr_load_valid", 32'(a_valid), 32'd1);
        check_eq("rr_load_instr", a_instr,      mk(32'h100));
        check_eq("rr_next_addr",  a_addr,       32'h0000_0104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
